fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the byte address into instruction memory.
- Selects the next PC from sequential, branch, jump or jump-register sources.
- Captures the returned instruction word into an IF/ID register, with stall, flush and an address-fault trap.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 56, number of valid 32-bit words in instruction memory; byte addresses at or above 4*IMEM_WORDS are out of range.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard stall; freezes PC and IF/ID.
- flush_i  in  1  squash the instruction being captured this cycle.
- branch_taken_i  in  1  take branch_target_i.
- branch_target_i  in  32  byte address.
- jump_i  in  1  J-type jump.
- jump_index_i  in  26  J-type index field.
- jr_i  in  1  jump-register.
- jr_addr_i  in  32  byte address from the register file.
- imem_addr_o  out  32  byte address to instruction memory; equals the PC.
- imem_data_i  in  32  word returned combinationally by instruction memory.
- if_id_instr_o  out  32  captured instruction.
- if_id_pc4_o  out  32  PC+4 of the captured instruction.
- if_id_valid_o  out  1  captured instruction is real, not a bubble.
- fault_o  out  1  fetch fault trap is active.
- fetch_count_o  out  32  number of valid instructions captured; saturates.

Behaviour:
- Reset (async, rst_n=0) sets the following immediately:
  - PC=RESET_PC.
  - if_id_instr_o=32'h0 (NOP).
  - if_id_pc4_o=0.
  - if_id_valid_o=0.
  - fault_o=0.
  - fetch_count_o=0.
  - state=RUN.
- Reset release is synchronous to the first rising clk edge after rst_n=1.
- imem_addr_o = PC, continuously. Memory is combinational, so each fetch takes 1 cycle: the word at PC is captured into IF/ID on the next rising edge.
- pc4 = PC+4, modulo 2^32.
- Next-PC priority, highest first:
  - jr_i: jr_addr_i.
  - jump_i: {pc4[31:28], jump_index_i, 2'b00}.
  - branch_taken_i: branch_target_i.
  - otherwise: pc4.
- A redirect is any of jr_i, jump_i or branch_taken_i.
- RUN state, stall_i=1:
  - PC, IF/ID and fetch_count_o all hold.
  - Redirect and flush inputs are ignored; the requester must hold them until the stall drops.
- RUN state, stall_i=0:
  - PC loads next-PC.
  - If flush_i=1 or a redirect is asserted: IF/ID is loaded with instr=32'h0, pc4=pc4, valid=0.
  - Otherwise: IF/ID is loaded with instr=imem_data_i, pc4=pc4, valid=1, and fetch_count_o increments.
- fetch_count_o saturates at 32'hFFFF_FFFF.
- Fault check applies in RUN state with stall_i=0, to the candidate next-PC. The candidate faults if either:
  - its bits [1:0] != 2'b00 (misaligned), or
  - it is >= 4*IMEM_WORDS (out of range).
- On a faulting cycle:
  - PC does not update.
  - IF/ID loads a bubble (NOP, valid=0).
  - Next state is FAULT and fault_o=1 from the following cycle.
  - The instruction at the current PC is not counted.
- FAULT state:
  - PC, fault_o=1 and fetch_count_o hold.
  - IF/ID is a bubble every cycle.
  - All inputs except rst_n are ignored; reset is the only exit.
- Reset asserted mid-operation, including during a stall or in FAULT, takes effect immediately with the values listed above.
- The sequential path reaching 4*IMEM_WORDS is a fault.

Test Plan:
- Reset, then 4 cycles with no stall and memory words 0x11,0x22,0x33,0x44:
  - imem_addr_o sequence 0,4,8,12,16.
  - IF/ID captures 0x11..0x44 with pc4 4..16, valid=1.
  - fetch_count_o=4.
- At PC=8, assert branch_taken_i=1 with branch_target_i=0x20 for 1 cycle:
  - PC becomes 0x20.
  - IF/ID becomes NOP, valid=0.
  - The next cycle captures mem[8].
- At PC=0x10, assert jump_i, jr_i and branch_taken_i together with jr_addr_i=0x40:
  - PC becomes 0x40, since jr wins.
  - A bubble is inserted.
  - fetch_count_o does not increment.
- Hold stall_i=1 for 3 cycles while a jump is requested:
  - PC, IF/ID and fetch_count_o are frozen.
  - After release, the held jump_index_i=0x5 sends PC to 0x14.
- Drive jr_addr_i=0x06 (misaligned), then separately branch_target_i=0xE0 (equal to 4*56):
  - PC stays unchanged.
  - fault_o=1 on the next cycle and stays 1 across 5 cycles of arbitrary inputs.
- In FAULT, assert rst_n=0 mid-cycle:
  - Outputs return to reset values immediately.
  - Fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives imem address, captures the returned word into IF/ID.
// Latency: 1 cycle from PC to IF/ID (imem is combinational); redirects insert one bubble.
// Backpressure: stall_i freezes PC, IF/ID and counter; a bad next-PC traps into FAULT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 56
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // First byte address past the end of instruction memory; 33 bits so the
    // compare cannot wrap for any 32-bit candidate.
    localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) << 2;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc4;
    logic [31:0] cand_pc;
    logic        redirect;
    logic        cand_fault;
    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;
    logic [31:0] count_nxt;

    assign imem_addr_o = pc;
    assign fault_o     = (state == FAULT);

    // Candidate next-PC selection (jr > jump > branch > sequential) and its fault check.
    always_comb begin
        pc4      = pc + 32'd4;
        redirect = jr_i | jump_i | branch_taken_i;
        if (jr_i) begin
            cand_pc = jr_addr_i;
        end else if (jump_i) begin
            cand_pc = {pc4[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            cand_pc = branch_target_i;
        end else begin
            cand_pc = pc4;
        end
        cand_fault = (cand_pc[1:0] != 2'b00) || ({1'b0, cand_pc} >= ADDR_LIMIT);
    end

    // Next-state and next-register values; holding is the default so stalls fall out naturally.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr_o;
        pc4_nxt   = if_id_pc4_o;
        valid_nxt = if_id_valid_o;
        count_nxt = fetch_count_o;
        case (state)
            RUN: begin
                if (!stall_i) begin
                    if (cand_fault) begin
                        // PC stays on the last good address so it can be inspected after the trap.
                        state_nxt = FAULT;
                        instr_nxt = 32'h0;
                        valid_nxt = 1'b0;
                    end else begin
                        pc_nxt  = cand_pc;
                        pc4_nxt = pc4;
                        if (flush_i || redirect) begin
                            instr_nxt = 32'h0;
                            valid_nxt = 1'b0;
                        end else begin
                            instr_nxt = imem_data_i;
                            valid_nxt = 1'b1;
                            if (fetch_count_o != 32'hFFFF_FFFF) begin
                                count_nxt = fetch_count_o + 32'd1;
                            end
                        end
                    end
                end
            end
            FAULT: begin
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = FAULT;
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC, IF/ID and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            if_id_instr_o <= 32'h0;
            if_id_pc4_o   <= 32'h0;
            if_id_valid_o <= 1'b0;
            fetch_count_o <= 32'h0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            if_id_instr_o <= instr_nxt;
            if_id_pc4_o   <= pc4_nxt;
            if_id_valid_o <= valid_nxt;
            fetch_count_o <= count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a behavioural fetch model.
// Latency: model advances once per rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: stall, redirect and fault scenarios driven directly, then randomized traffic.
module tb_fetch_unit;

    localparam int WORDS = 56;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, branch_taken_i, jump_i, jr_i;
    logic [31:0] branch_target_i, jr_addr_i;
    logic [25:0] jump_index_i;
    logic [31:0] imem_addr_o, imem_data_i;
    logic [31:0] if_id_instr_o, if_id_pc4_o, fetch_count_o;
    logic        if_id_valid_o, fault_o;

    logic [31:0] mem [0:WORDS-1];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_index_i   (jump_index_i),
        .jr_i           (jr_i),
        .jr_addr_i      (jr_addr_i),
        .imem_addr_o    (imem_addr_o),
        .imem_data_i    (imem_data_i),
        .if_id_instr_o  (if_id_instr_o),
        .if_id_pc4_o    (if_id_pc4_o),
        .if_id_valid_o  (if_id_valid_o),
        .fault_o        (fault_o),
        .fetch_count_o  (fetch_count_o)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return a marker word.
    always_comb begin
        if (imem_addr_o < 32'(WORDS * 4) && imem_addr_o[1:0] == 2'b00)
            imem_data_i = mem[imem_addr_o[7:2]];
        else
            imem_data_i = 32'hBAD0_C0DE;
    end

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0; jr_i = 0;
        branch_target_i = 0; jr_addr_i = 0; jump_index_i = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_count = 0; m_valid = 0; m_fault = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then let the DUT clock.
    task automatic step();
        logic [31:0] seq, tgt;
        if (!m_fault && !stall_i) begin
            seq = m_pc + 4;
            if (jr_i)                tgt = jr_addr_i;
            else if (jump_i)         tgt = {seq[31:28], jump_index_i, 2'b00};
            else if (branch_taken_i) tgt = branch_target_i;
            else                     tgt = seq;
            if (tgt % 4 != 0 || tgt >= WORDS * 4) begin
                m_fault = 1; m_instr = 0; m_valid = 0;
            end else begin
                m_pc4 = seq;
                if (flush_i || jr_i || jump_i || branch_taken_i) begin
                    m_instr = 0; m_valid = 0;
                end else begin
                    m_instr = mem[m_pc / 4]; m_valid = 1;
                    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                end
                m_pc = tgt;
            end
        end else if (m_fault) begin
            m_instr = 0; m_valid = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_addr_o !== 32'h0 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0 ||
            if_id_valid_o !== 1'b0 || fault_o !== 1'b0 || fetch_count_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: addr=%h instr=%h pc4=%h valid=%b fault=%b count=%0d, want all zero",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fault_o, fetch_count_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want_instr [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) mem[i] = want_instr[i];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_addr_o !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr_o, i * 4);
            end
            step();
            checks++;
            if (if_id_instr_o !== want_instr[i] || if_id_pc4_o !== 32'(i * 4 + 4) || if_id_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_capture[%0d]: got instr=%h pc4=%h valid=%b want %h %h 1",
                         i, if_id_instr_o, if_id_pc4_o, if_id_valid_o, want_instr[i], i * 4 + 4);
            end
        end
        checks++;
        if (imem_addr_o !== 32'd16 || fetch_count_o !== 32'd4) begin
            errors++;
            $display("FAIL seq_end: got addr=%h count=%0d want 10 4", imem_addr_o, fetch_count_o);
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(); step();
        branch_taken_i = 1; branch_target_i = 32'h20;
        step();
        branch_taken_i = 0;
        checks++;
        if (imem_addr_o !== 32'h20 || if_id_instr_o !== 32'h0 || if_id_valid_o !== 1'b0 ||
            if_id_pc4_o !== 32'hC || fetch_count_o !== 32'd2) begin
            errors++;
            $display("FAIL branch_bubble: got addr=%h instr=%h valid=%b pc4=%h count=%0d want 20 0 0 c 2",
                     imem_addr_o, if_id_instr_o, if_id_valid_o, if_id_pc4_o, fetch_count_o);
        end
        step();
        checks++;
        if (if_id_instr_o !== mem[8] || if_id_valid_o !== 1'b1 || if_id_pc4_o !== 32'h24) begin
            errors++;
            $display("FAIL branch_target_fetch: got instr=%h valid=%b pc4=%h want %h 1 24",
                     if_id_instr_o, if_id_valid_o, if_id_pc4_o, mem[8]);
        end
    endtask

    task automatic test_jr_priority();
        do_reset();
        repeat (4) step();
        jr_i = 1; jump_i = 1; branch_taken_i = 1;
        jr_addr_i = 32'h40; jump_index_i = 26'h3; branch_target_i = 32'h8;
        step();
        clear_inputs();
        checks++;
        if (imem_addr_o !== 32'h40 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || fetch_count_o !== 32'd4) begin
            errors++;
            $display("FAIL jr_priority: got addr=%h valid=%b instr=%h count=%0d want 40 0 0 4",
                     imem_addr_o, if_id_valid_o, if_id_instr_o, fetch_count_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] h_instr, h_pc4, h_count;
        do_reset();
        step();
        h_instr = if_id_instr_o; h_pc4 = if_id_pc4_o; h_count = fetch_count_o;
        stall_i = 1; jump_i = 1; jump_index_i = 26'h5; flush_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_addr_o !== 32'h4 || if_id_instr_o !== h_instr || if_id_pc4_o !== h_pc4 ||
                if_id_valid_o !== 1'b1 || fetch_count_o !== h_count) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pc4=%h valid=%b count=%0d want 4 %h %h 1 %0d",
                         i, imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fetch_count_o,
                         h_instr, h_pc4, h_count);
            end
        end
        stall_i = 0; flush_i = 0;
        step();
        clear_inputs();
        checks++;
        if (imem_addr_o !== 32'h14 || if_id_valid_o !== 1'b0 || fetch_count_o !== h_count) begin
            errors++;
            $display("FAIL stall_release_jump: got addr=%h valid=%b count=%0d want 14 0 %0d",
                     imem_addr_o, if_id_valid_o, fetch_count_o, h_count);
        end
    endtask

    task automatic test_fault(input bit use_branch);
        logic [31:0] h_pc, h_count;
        do_reset();
        step(); step();
        h_pc = imem_addr_o; h_count = fetch_count_o;
        if (use_branch) begin branch_taken_i = 1; branch_target_i = 32'hE0; end
        else            begin jr_i = 1; jr_addr_i = 32'h6; end
        checks++;
        if (fault_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_early[%0d]: got %b want 0", use_branch, fault_o);
        end
        step();
        checks++;
        if (fault_o !== 1'b1 || imem_addr_o !== h_pc || if_id_valid_o !== 1'b0 || fetch_count_o !== h_count) begin
            errors++;
            $display("FAIL fault_entry[%0d]: got fault=%b addr=%h valid=%b count=%0d want 1 %h 0 %0d",
                     use_branch, fault_o, imem_addr_o, if_id_valid_o, fetch_count_o, h_pc, h_count);
        end
        for (int i = 0; i < 5; i++) begin
            {stall_i, flush_i, branch_taken_i, jump_i, jr_i} = 5'($urandom);
            branch_target_i = $urandom_range(0, 55) * 4; jr_addr_i = $urandom_range(0, 55) * 4;
            jump_index_i = 26'($urandom_range(0, 55));
            step();
            checks++;
            if (fault_o !== 1'b1 || imem_addr_o !== h_pc || if_id_valid_o !== 1'b0 ||
                if_id_instr_o !== 32'h0 || fetch_count_o !== h_count) begin
                errors++;
                $display("FAIL fault_hold[%0d.%0d]: got fault=%b addr=%h valid=%b instr=%h count=%0d want 1 %h 0 0 %0d",
                         use_branch, i, fault_o, imem_addr_o, if_id_valid_o, if_id_instr_o, fetch_count_o, h_pc, h_count);
            end
        end
        clear_inputs();
    endtask

    task automatic test_seq_end();
        do_reset();
        repeat (WORDS - 1) step();
        checks++;
        if (imem_addr_o !== 32'hDC || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL seq_last_word: got addr=%h fault=%b want dc 0", imem_addr_o, fault_o);
        end
        step();
        checks++;
        if (fault_o !== 1'b1 || imem_addr_o !== 32'hDC || fetch_count_o !== 32'd55) begin
            errors++;
            $display("FAIL seq_overrun: got fault=%b addr=%h count=%0d want 1 dc 55", fault_o, imem_addr_o, fetch_count_o);
        end
    endtask

    task automatic test_fault_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (imem_addr_o !== 32'h0 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0 ||
            if_id_valid_o !== 1'b0 || fault_o !== 1'b0 || fetch_count_o !== 32'h0) begin
            errors++;
            $display("FAIL fault_async_reset: addr=%h instr=%h pc4=%h valid=%b fault=%b count=%0d want all zero",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fault_o, fetch_count_o);
        end
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        step();
        checks++;
        if (imem_addr_o !== 32'h4 || if_id_instr_o !== mem[0] || if_id_valid_o !== 1'b1 || fetch_count_o !== 32'd1) begin
            errors++;
            $display("FAIL fault_resume: got addr=%h instr=%h valid=%b count=%0d want 4 %h 1 1",
                     imem_addr_o, if_id_instr_o, if_id_valid_o, fetch_count_o, mem[0]);
        end
    endtask

    task automatic test_random();
        int fault_cycles = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall_i        = ($urandom_range(0, 9) < 2);
            flush_i        = ($urandom_range(0, 9) == 0);
            branch_taken_i = ($urandom_range(0, 9) == 0);
            jump_i         = ($urandom_range(0, 19) == 0);
            jr_i           = ($urandom_range(0, 19) == 0);
            branch_target_i = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 55) * 4;
            jr_addr_i       = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 55) * 4;
            jump_index_i    = 26'($urandom_range(0, 63));
            step();
            checks++;
            if (imem_addr_o !== m_pc || if_id_instr_o !== m_instr || if_id_pc4_o !== m_pc4 ||
                if_id_valid_o !== m_valid || fault_o !== m_fault || fetch_count_o !== m_count) begin
                errors++;
                $display("FAIL random[%0d]: got addr=%h instr=%h pc4=%h v=%b f=%b cnt=%0d want %h %h %h %b %b %0d",
                         i, imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fault_o, fetch_count_o,
                         m_pc, m_instr, m_pc4, m_valid, m_fault, m_count);
            end
            if (m_fault) fault_cycles++;
            if (fault_cycles > 3) begin
                fault_cycles = 0;
                do_reset();
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        clear_inputs();
        model_reset();
        rst_n = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jr_priority();
        test_stall();
        test_fault(1'b0);
        test_fault(1'b1);
        test_seq_end();
        test_fault_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
